// File: rtl/mem_stage.sv
// Memory stage: EX/WB pipeline register plus a req/gnt/rvalid data-bus master that performs
// byte-lane alignment of stores and extraction/extension of loads.
package mem_stage_pkg;
  typedef enum logic {LSU_OP_LD = 1'b0, LSU_OP_ST = 1'b1} lsu_op_e;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_ex,
  input  logic [31:0]          pc_ex,
  input  logic                 rd_wr_en_ex,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_ex,
  input  logic [4:0]           rd_wr_addr_ex,
  input  logic [31:0]          rd_wr_data_ex,
  input  logic                 lsu_en_ex,
  input  lsu_op_e              lsu_op_ex,
  input  logic [1:0]           lsu_size_ex,
  input  logic                 lsu_unsigned_ex,
  input  logic [31:0]          lsu_wdata_ex,
  input  logic                 flush_M,
  output logic                 ready_mem,
  output logic                 data_req,
  input  logic                 data_gnt,
  output logic [31:0]          data_addr,
  output logic                 data_we,
  output logic [3:0]           data_be,
  output logic [31:0]          data_wdata,
  input  logic                 data_rvalid,
  input  logic [31:0]          data_rdata,
  input  logic                 ready_wb,
  output logic [31:0]          pc_wb,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic                 lsu_en_wb,
  output lsu_op_e              lsu_op_wb,
  output logic [31:0]          lsu_rdata_wb,
  output logic                 lsu_valid_wb,
  output logic                 lsu_err_wb
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                 r_state, w_state_nxt;
  logic                   r_valid;
  logic [31:0]            r_pc;
  logic                   r_rd_wr_en;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [4:0]             r_rd_addr;
  logic [31:0]            r_rd_data;
  logic                   r_lsu_en;
  lsu_op_e                r_lsu_op;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata, w_rdata_nxt;
  logic                   r_err, w_err_nxt;

  logic                   w_advance;
  logic                   w_load_valid;
  logic                   w_ex_misaligned;
  logic [1:0]             w_off;
  logic                   w_req;
  logic [31:0]            w_shifted;
  logic [31:0]            w_load_ext;

  assign ready_mem    = ~r_valid | ready_wb;
  assign w_advance    = ready_mem;
  assign w_load_valid = valid_ex & ~flush_M;
  // Size 3 is reserved and behaves as a word access.
  assign w_ex_misaligned = ((lsu_size_ex == 2'd1) & rd_wr_data_ex[0]) |
                           (lsu_size_ex[1] & (rd_wr_data_ex[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd_wr_en <= 1'b0;
      r_tag      <= '0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_lsu_en   <= 1'b0;
      r_lsu_op   <= LSU_OP_LD;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
    end else if (w_advance) begin
      r_valid    <= w_load_valid;
      r_pc       <= pc_ex;
      r_rd_wr_en <= rd_wr_en_ex & w_load_valid;
      r_tag      <= rd_wr_tag_ex;
      r_rd_addr  <= rd_wr_addr_ex;
      r_rd_data  <= rd_wr_data_ex;
      r_lsu_en   <= lsu_en_ex & w_load_valid;
      r_lsu_op   <= lsu_op_ex;
      r_size     <= lsu_size_ex;
      r_unsigned <= lsu_unsigned_ex;
      r_wdata    <= lsu_wdata_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= StIdle;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_off     = r_rd_data[1:0];
  assign w_shifted = data_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    unique case (r_size)
      2'd0:    w_load_ext = r_unsigned ? {24'b0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load_ext = r_unsigned ? {16'b0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    if (w_advance) begin
      w_rdata_nxt = '0;
      w_err_nxt   = 1'b0;
      if (lsu_en_ex & w_load_valid) begin
        if (w_ex_misaligned) begin
          w_state_nxt = StDone;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = StReq;
        end
      end else begin
        w_state_nxt = StIdle;
      end
    end else begin
      unique case (r_state)
        StReq: if (data_gnt) w_state_nxt = StWait;
        StWait: begin
          if (data_rvalid) begin
            w_state_nxt = StDone;
            w_rdata_nxt = (r_lsu_op == LSU_OP_LD) ? w_load_ext : 32'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus fields are forced to zero outside a request so idle/reset outputs are all zero.
  assign w_req    = (r_state == StReq);
  assign data_req = w_req;

  always_comb begin
    data_addr  = '0;
    data_we    = 1'b0;
    data_be    = '0;
    data_wdata = '0;
    if (w_req) begin
      data_addr = {r_rd_data[31:2], 2'b00};
      data_we   = (r_lsu_op == LSU_OP_ST);
      unique case (r_size)
        2'd0: begin
          data_be    = 4'b0001 << w_off;
          data_wdata = {4{r_wdata[7:0]}};
        end
        2'd1: begin
          data_be    = 4'b0011 << w_off;
          data_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          data_be    = 4'b1111;
          data_wdata = r_wdata;
        end
      endcase
    end
  end

  assign pc_wb         = r_pc;
  assign rd_wr_en_wb   = r_rd_wr_en;
  assign rd_wr_tag_wb  = r_tag;
  assign rd_wr_addr_wb = r_rd_addr;
  assign rd_wr_data_wb = r_rd_data;
  assign lsu_en_wb     = r_lsu_en;
  assign lsu_op_wb     = r_lsu_op;
  assign lsu_rdata_wb  = r_rdata;
  assign lsu_valid_wb  = (r_state == StDone);
  assign lsu_err_wb    = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, aligned/misaligned loads and stores,
// bus stalls, writeback back-pressure, reset mid-transaction and flush.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TagW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            valid_ex;
  logic [31:0]     pc_ex;
  logic            rd_wr_en_ex;
  logic [TagW-1:0] rd_wr_tag_ex;
  logic [4:0]      rd_wr_addr_ex;
  logic [31:0]     rd_wr_data_ex;
  logic            lsu_en_ex;
  lsu_op_e         lsu_op_ex;
  logic [1:0]      lsu_size_ex;
  logic            lsu_unsigned_ex;
  logic [31:0]     lsu_wdata_ex;
  logic            flush_M;
  logic            ready_mem;
  logic            data_req;
  logic            data_gnt;
  logic [31:0]     data_addr;
  logic            data_we;
  logic [3:0]      data_be;
  logic [31:0]     data_wdata;
  logic            data_rvalid;
  logic [31:0]     data_rdata;
  logic            ready_wb;
  logic [31:0]     pc_wb;
  logic            rd_wr_en_wb;
  logic [TagW-1:0] rd_wr_tag_wb;
  logic [4:0]      rd_wr_addr_wb;
  logic [31:0]     rd_wr_data_wb;
  logic            lsu_en_wb;
  lsu_op_e         lsu_op_wb;
  logic [31:0]     lsu_rdata_wb;
  logic            lsu_valid_wb;
  logic            lsu_err_wb;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TAG_WIDTH(TagW)) dut (
    .clk(clk), .reset_n(reset_n), .valid_ex(valid_ex), .pc_ex(pc_ex),
    .rd_wr_en_ex(rd_wr_en_ex), .rd_wr_tag_ex(rd_wr_tag_ex), .rd_wr_addr_ex(rd_wr_addr_ex),
    .rd_wr_data_ex(rd_wr_data_ex), .lsu_en_ex(lsu_en_ex), .lsu_op_ex(lsu_op_ex),
    .lsu_size_ex(lsu_size_ex), .lsu_unsigned_ex(lsu_unsigned_ex), .lsu_wdata_ex(lsu_wdata_ex),
    .flush_M(flush_M), .ready_mem(ready_mem), .data_req(data_req), .data_gnt(data_gnt),
    .data_addr(data_addr), .data_we(data_we), .data_be(data_be), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .ready_wb(ready_wb), .pc_wb(pc_wb),
    .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_tag_wb(rd_wr_tag_wb), .rd_wr_addr_wb(rd_wr_addr_wb),
    .rd_wr_data_wb(rd_wr_data_wb), .lsu_en_wb(lsu_en_wb), .lsu_op_wb(lsu_op_wb),
    .lsu_rdata_wb(lsu_rdata_wb), .lsu_valid_wb(lsu_valid_wb), .lsu_err_wb(lsu_err_wb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ex_idle();
    valid_ex    = 1'b0;
    lsu_en_ex   = 1'b0;
    rd_wr_en_ex = 1'b0;
    flush_M     = 1'b0;
  endtask

  task automatic ex_lsu(input lsu_op_e op, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    valid_ex        = 1'b1;
    lsu_en_ex       = 1'b1;
    lsu_op_ex       = op;
    lsu_size_ex     = sz;
    lsu_unsigned_ex = uns;
    rd_wr_data_ex   = addr;
    lsu_wdata_ex    = wd;
    rd_wr_en_ex     = (op == LSU_OP_LD);
    rd_wr_addr_ex   = 5'd9;
    rd_wr_tag_ex    = 4'h3;
    pc_ex           = 32'h0000_0200;
  endtask

  initial begin
    reset_n = 1'b1; ex_idle(); pc_ex = '0; rd_wr_tag_ex = '0; rd_wr_addr_ex = '0;
    rd_wr_data_ex = '0; lsu_op_ex = LSU_OP_LD; lsu_size_ex = '0; lsu_unsigned_ex = 1'b0;
    lsu_wdata_ex = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; ready_wb = 1'b0;
    repeat (3) nxt();

    // Reset state
    smp();
    chk("rst_req", data_req, 0);
    chk("rst_valid", lsu_valid_wb, 0);
    chk("rst_rdwren", rd_wr_en_wb, 0);
    chk("rst_lsuen", lsu_en_wb, 0);
    chk("rst_pc", pc_wb, 0);
    chk("rst_be", data_be, 0);
    nxt();
    reset_n = 1'b0;

    // 1: ALU instruction passes through in one cycle
    valid_ex = 1'b1; rd_wr_en_ex = 1'b1; rd_wr_addr_ex = 5'd5; rd_wr_data_ex = 32'h1234;
    rd_wr_tag_ex = 4'hA; pc_ex = 32'h100; lsu_en_ex = 1'b0; ready_wb = 1'b1;
    smp();
    chk("alu_rdy0", ready_mem, 1);
    nxt();
    ex_idle();
    smp();
    chk("alu_wren", rd_wr_en_wb, 1);
    chk("alu_data", rd_wr_data_wb, 32'h1234);
    chk("alu_addr", rd_wr_addr_wb, 5);
    chk("alu_tag", rd_wr_tag_wb, 4'hA);
    chk("alu_pc", pc_wb, 32'h100);
    chk("alu_lsuen", lsu_en_wb, 0);
    chk("alu_rdy1", ready_mem, 1);
    nxt();

    // 2: LB 0x1003, immediate grant, rvalid next cycle
    ex_lsu(LSU_OP_LD, 2'd0, 1'b0, 32'h1003, 32'h0);
    ready_wb = 1'b0; data_gnt = 1'b1;
    smp();
    chk("lb_rdy0", ready_mem, 1);
    nxt();
    ex_idle();
    smp();
    chk("lb_req", data_req, 1);
    chk("lb_addr", data_addr, 32'h1000);
    chk("lb_be", data_be, 4'b1000);
    chk("lb_we", data_we, 0);
    chk("lb_rdy1", ready_mem, 0);
    nxt();
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h80FF_0000;
    smp();
    chk("lb_rdy2", ready_mem, 0);
    chk("lb_req2", data_req, 0);
    chk("lb_val2", lsu_valid_wb, 0);
    nxt();
    data_rvalid = 1'b0;
    smp();
    chk("lb_val3", lsu_valid_wb, 1);
    chk("lb_rdata", lsu_rdata_wb, 32'hFFFF_FF80);
    chk("lb_lsuen", lsu_en_wb, 1);
    ready_wb = 1'b1;
    nxt();

    // 3: SH 0x2002, grant held off three cycles
    ex_lsu(LSU_OP_ST, 2'd1, 1'b0, 32'h2002, 32'hABCD_1234);
    ready_wb = 1'b0; data_gnt = 1'b0;
    smp();
    nxt();
    ex_idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_gnt = 1'b1;
      smp();
      chk($sformatf("sh_req%0d", i), data_req, 1);
      chk($sformatf("sh_addr%0d", i), data_addr, 32'h2000);
      chk($sformatf("sh_be%0d", i), data_be, 4'b1100);
      chk($sformatf("sh_wd%0d", i), data_wdata, 32'h1234_1234);
      chk($sformatf("sh_we%0d", i), data_we, 1);
      nxt();
    end
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h5555_5555;
    smp();
    chk("sh_req_wait", data_req, 0);
    chk("sh_val_wait", lsu_valid_wb, 0);
    nxt();
    data_rvalid = 1'b0;
    smp();
    chk("sh_val", lsu_valid_wb, 1);
    chk("sh_rdata", lsu_rdata_wb, 0);
    chk("sh_err", lsu_err_wb, 0);
    ready_wb = 1'b1;
    nxt();

    // 4: misaligned LW 0x3001 never reaches the bus
    ex_lsu(LSU_OP_LD, 2'd2, 1'b0, 32'h3001, 32'h0);
    ready_wb = 1'b0; data_gnt = 1'b1;
    smp();
    nxt();
    ex_idle();
    smp();
    chk("lwm_req", data_req, 0);
    chk("lwm_val", lsu_valid_wb, 1);
    chk("lwm_err", lsu_err_wb, 1);
    chk("lwm_rdata", lsu_rdata_wb, 0);
    ready_wb = 1'b1;
    nxt();

    // 5: LHU 0x4002 with writeback back-pressure in DONE
    ex_lsu(LSU_OP_LD, 2'd1, 1'b1, 32'h4002, 32'h0);
    ready_wb = 1'b0; data_gnt = 1'b1;
    smp();
    nxt();
    ex_idle();
    smp();
    chk("lhu_req", data_req, 1);
    chk("lhu_be", data_be, 4'b1100);
    nxt();
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h8001_0000;
    smp();
    nxt();
    data_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("lhu_val%0d", i), lsu_valid_wb, 1);
      chk($sformatf("lhu_rd%0d", i), lsu_rdata_wb, 32'h0000_8001);
      chk($sformatf("lhu_rdy%0d", i), ready_mem, 0);
      chk($sformatf("lhu_req%0d", i), data_req, 0);
      if (i == 2) ready_wb = 1'b1;
      nxt();
    end
    smp();
    chk("lhu_retired", lsu_valid_wb, 0);
    chk("lhu_clr", lsu_rdata_wb, 0);
    ready_wb = 1'b0;
    nxt();

    // 6: reset while waiting for rvalid, late rvalid ignored
    ex_lsu(LSU_OP_LD, 2'd2, 1'b0, 32'h5000, 32'h0);
    data_gnt = 1'b1;
    smp();
    nxt();
    ex_idle();
    smp();
    chk("rw_req", data_req, 1);
    nxt();
    data_gnt = 1'b0; reset_n = 1'b1;
    smp();
    nxt();
    reset_n = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF;
    smp();
    chk("rw_req_rst", data_req, 0);
    chk("rw_val_rst", lsu_valid_wb, 0);
    chk("rw_lsuen_rst", lsu_en_wb, 0);
    chk("rw_wren_rst", rd_wr_en_wb, 0);
    chk("rw_pc_rst", pc_wb, 0);
    nxt();
    data_rvalid = 1'b0;
    smp();
    chk("rw_val_late", lsu_valid_wb, 0);
    chk("rw_rd_late", lsu_rdata_wb, 0);
    chk("rw_req_late", data_req, 0);
    nxt();

    // flush_M turns a valid load into a bubble
    ex_lsu(LSU_OP_LD, 2'd2, 1'b0, 32'h6000, 32'h0);
    flush_M = 1'b1; data_gnt = 1'b1;
    smp();
    nxt();
    ex_idle();
    smp();
    chk("fl_req", data_req, 0);
    chk("fl_lsuen", lsu_en_wb, 0);
    chk("fl_wren", rd_wr_en_wb, 0);
    chk("fl_rdy", ready_mem, 1);
    nxt();
    data_gnt = 1'b0;
    smp();
    chk("fl_req2", data_req, 0);
    chk("fl_val2", lsu_valid_wb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage between execute and wb_stage. Holds the EX/WB pipeline register.
- For load/store instructions it runs the data-bus req/gnt/rvalid transaction: byte-lane alignment, byte enables, store-data replication, load extraction and sign/zero extension.
- Presents lsu_valid_wb/lsu_rdata_wb to wb_stage and stalls upstream until wb_stage retires the held instruction.

Parameters:
TAG_WIDTH  4  width of rd write tag carried to writeback

Ports:
clk  input  1  clock
reset_n  input  1  synchronous reset, active-high (1 = reset); sampled on rising clk
valid_ex  input  1  EX slot holds a valid instruction
pc_ex  input  32  instruction PC
rd_wr_en_ex  input  1  instruction writes rd
rd_wr_tag_ex  input  TAG_WIDTH  rd write tag
rd_wr_addr_ex  input  5  rd index
rd_wr_data_ex  input  32  ALU result; the effective address when lsu_en_ex=1
lsu_en_ex  input  1  load/store instruction
lsu_op_ex  input  lsu_op_e  LSU_OP_LD / LSU_OP_ST
lsu_size_ex  input  2  0=byte, 1=half, 2=word (3 reserved, treated as word)
lsu_unsigned_ex  input  1  zero-extend load result
lsu_wdata_ex  input  32  store data, right-aligned
flush_M  input  1  kill the instruction entering from EX
ready_mem  output  1  stage accepts EX instruction this cycle
data_req  output  1  bus request
data_gnt  input  1  bus grant
data_addr  output  32  word-aligned address
data_we  output  1  1=store
data_be  output  4  byte enables
data_wdata  output  32  lane-replicated store data
data_rvalid  input  1  response valid (load data or store ack)
data_rdata  input  32  load word
ready_wb  input  1  wb_stage retires held instruction
pc_wb, rd_wr_en_wb, rd_wr_tag_wb, rd_wr_addr_wb, rd_wr_data_wb, lsu_en_wb, lsu_op_wb  output  as EX counterparts  registered copies
lsu_rdata_wb  output  32  aligned/extended load data
lsu_valid_wb  output  1  LSU access complete
lsu_err_wb  output  1  misaligned access, no bus transaction performed

Behaviour:
- **Reset:**
  - All outputs 0; state IDLE; WB register holds a bubble.
  - Reset mid-transaction drops data_req next cycle.
  - Any later data_rvalid is ignored while in IDLE/DONE.
- **Advance:**
  - ready_mem = ~held_valid | ready_wb.
  - On a rising edge with ready_mem=1, the WB register loads the EX fields.
  - A bubble is loaded if valid_ex=0 or flush_M=1. A bubble forces rd_wr_en_wb=0 and lsu_en_wb=0.
- **Latched at load time:** byte offset off = rd_wr_data_ex[1:0], size, unsigned flag, wdata.
- **Misalignment:** misaligned = (half & off[0]) | (word & off≠0).
- **FSM states:** IDLE, REQ, WAIT, DONE.
  - Load of a non-misaligned LSU instruction → REQ.
  - Load of a misaligned LSU instruction → DONE with lsu_err_wb=1, lsu_rdata_wb=0.
  - Load of a non-LSU instruction or bubble → IDLE.
  - REQ: data_req=1, held until data_gnt. Never retracted, even on flush. On gnt → WAIT.
  - WAIT: on data_rvalid → DONE. lsu_rdata_wb is registered (loads) or 0 (stores).
  - DONE: lsu_valid_wb=1 until the WB register advances.
  - Any advance re-evaluates the state from the new contents.
  - data_rvalid is never expected in the same cycle as gnt; it arrives at least 1 cycle after.
- **Bus fields** (from held registers, stable while data_req=1):
  - data_addr = {addr[31:2],2'b00}; data_we = (lsu_op==LSU_OP_ST).
  - data_be: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111.
  - data_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- **Load extract:** w = data_rdata >> (8*off); byte/half then sign-extended (or zero-extended if unsigned); word = w.
- **Latency:** with gnt in the first REQ cycle and rvalid on the next cycle, lsu_valid_wb rises 3 cycles after acceptance. Non-LSU instructions leave after 1 cycle when ready_wb=1.
- **flush_W:** is wb_stage's concern; this block retires flushed instructions normally, completing any outstanding bus transaction.

Test Plan:
1. ALU instr, rd=5, data=0x1234, ready_wb=1 → next cycle rd_wr_en_wb=1, rd_wr_data_wb=0x1234, lsu_en_wb=0, ready_mem=1 throughout.
2. LB addr=0x1003, rdata=0x80FF_0000, gnt immediate, rvalid next cycle:
   - data_addr=0x1000, data_be=4'b1000.
   - lsu_rdata_wb=0xFFFF_FF80, lsu_valid_wb=1 on cycle 3.
   - ready_mem=0 on cycles 1-2.
3. SH addr=0x2002, wdata=0xABCD1234, gnt held off 3 cycles:
   - data_req and data_addr/be/wdata stable for 4 cycles.
   - data_be=4'b1100, data_wdata=0x1234_1234, data_we=1.
   - lsu_valid_wb after rvalid.
4. LW addr=0x3001 → data_req never asserted; next cycle lsu_valid_wb=1, lsu_err_wb=1, lsu_rdata_wb=0.
5. LHU addr=0x4002, rdata=0x8001_0000, ready_wb held 0 two extra cycles in DONE:
   - lsu_rdata_wb=0x0000_8001 held.
   - ready_mem=0; no second request.
6. Reset asserted in WAIT, rvalid arrives the cycle after reset → outputs 0, state IDLE, rvalid ignored. flush_M with valid_ex=1 → bubble loaded, no data_req.
